edge_centroid: RTL and testbench

- Downstream consumer of the Sobel edge map. Once the edge BRAM is full, it sweeps all 640x480 edge words in raster order.
- Accumulates edge-pixel count, bounding box and coordinate sums, then divides the sums sequentially to give the edge centroid.
- Results drive the overlay/tracking logic. The block runs once per start, with the same level-start/done convention as the edge detector.

---
 rtl/edge_centroid_pkg.sv | 24 ++
 rtl/edge_centroid_seq_divider.sv | 72 +++++++
 rtl/edge_centroid.sv | 193 +++++++++++++++++++
 tb/tb_edge_centroid.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/edge_centroid_pkg.sv
// Shared image geometry and state encoding for the edge-centroid block.
`default_nettype none

package edge_centroid_pkg;

  localparam int IMG_WIDTH  = 640;
  localparam int IMG_HEIGHT = 480;
  localparam int ADDR_W     = 19;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DIV_X  = 3'd3,
    ST_DIV_Y  = 3'd4,
    ST_FINISH = 3'd5,
    ST_HOLD   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/edge_centroid_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The start cycle
// already performs the first step, so a divide occupies DIVIDEND_W cycles.
`default_nettype none

module seq_divider #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 19,
  parameter int QUOT_W     = DIVIDEND_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_q, rem_in, rem_nxt, div_q, div_in, diff;
  logic [DIVIDEND_W-1:0] quo_q, quo_in, quo_nxt;
  logic [DIVISOR_W:0]    trial;
  logic                  fits;
  logic [CNT_W-1:0]      step_cnt;

  always_comb begin
    rem_in  = start ? '0       : rem_q;
    quo_in  = start ? dividend : quo_q;
    div_in  = start ? divisor  : div_q;
    trial   = {rem_in, quo_in[DIVIDEND_W-1]};
    fits    = trial >= {1'b0, div_in};
    // When the trial fits, trial - divisor < divisor, so the low bits suffice.
    diff    = trial[DIVISOR_W-1:0] - div_in;
    rem_nxt = fits ? diff : trial[DIVISOR_W-1:0];
    quo_nxt = {quo_in[DIVIDEND_W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= rem_nxt;
        quo_q    <= quo_nxt;
        div_q    <= divisor;
        step_cnt <= CNT_W'(1);
        busy     <= 1'b1;
      end else if (busy) begin
        rem_q    <= rem_nxt;
        quo_q    <= quo_nxt;
        step_cnt <= step_cnt + CNT_W'(1);
        if (step_cnt == CNT_W'(DIVIDEND_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q[QUOT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/edge_centroid.sv
// Sweeps the edge BRAM once per start and reports edge count, bounding box
// and centroid of all nonzero edge pixels.
`default_nettype none

module edge_centroid
  import edge_centroid_pkg::*;
#(
  parameter int WIDTH     = IMG_WIDTH,
  parameter int HEIGHT    = IMG_HEIGHT,
  parameter int READ_LAT  = 2,
  parameter int MIN_COUNT = 1,
  parameter int SUM_W     = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  input  logic [3:0]        edge_data,
  output logic [ADDR_W-1:0] edge_memory_addr,
  output logic [ADDR_W-1:0] edge_count,
  output logic [X_W-1:0]    x_min,
  output logic [X_W-1:0]    x_max,
  output logic [Y_W-1:0]    y_min,
  output logic [Y_W-1:0]    y_max,
  output logic [X_W-1:0]    x_centroid,
  output logic [Y_W-1:0]    y_centroid,
  output logic              found
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [X_W-1:0]    X_LAST     = X_W'(WIDTH - 1);
  localparam logic [7:0]        DRAIN_LAST = 8'(READ_LAT - 1);

  state_t state, state_nxt;

  logic [ADDR_W-1:0]   addr, count, count_nxt;
  logic [X_W-1:0]      xpos, px, bx_min, bx_max, qx;
  logic [Y_W-1:0]      ypos, py, by_min, by_max;
  logic [READ_LAT-1:0] valid_pipe;
  logic [X_W-1:0]      x_pipe [READ_LAT];
  logic [Y_W-1:0]      y_pipe [READ_LAT];
  logic [SUM_W-1:0]    sum_x, sum_y, sum_x_nxt, sum_y_nxt, dividend;
  logic [7:0]          drain_cnt;
  logic                hit, scan_last, drain_last;
  logic                div_start, div_busy, div_done;
  logic [X_W-1:0]      quotient;

  assign edge_memory_addr = addr;
  assign px         = x_pipe[READ_LAT-1];
  assign py         = y_pipe[READ_LAT-1];
  assign hit        = valid_pipe[READ_LAT-1] && (edge_data != 4'd0) &&
                      (state == ST_SCAN || state == ST_DRAIN);
  assign count_nxt  = count + ADDR_W'(hit);
  assign sum_x_nxt  = sum_x + (hit ? SUM_W'(px) : '0);
  assign sum_y_nxt  = sum_y + (hit ? SUM_W'(py) : '0);
  assign scan_last  = (addr == LAST_ADDR);
  assign drain_last = (drain_cnt == DRAIN_LAST);
  // X divide launches on the final drain cycle using the not-yet-registered
  // totals, so the last in-flight pixel is included without an extra cycle.
  assign dividend   = (state == ST_DIV_X) ? sum_y : sum_x_nxt;

  seq_divider #(
    .DIVIDEND_W (SUM_W),
    .DIVISOR_W  (ADDR_W),
    .QUOT_W     (X_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (count_nxt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    if (!start) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = ST_SCAN;
        ST_SCAN:   if (scan_last) state_nxt = ST_DRAIN;
        ST_DRAIN: begin
          if (drain_last) begin
            if (count_nxt == '0) begin
              state_nxt = ST_FINISH;
            end else begin
              state_nxt = ST_DIV_X;
              div_start = 1'b1;
            end
          end
        end
        ST_DIV_X: begin
          if (!div_busy) begin
            state_nxt = ST_DIV_Y;
            div_start = 1'b1;
          end
        end
        ST_DIV_Y:  if (!div_busy) state_nxt = ST_FINISH;
        ST_FINISH: state_nxt = ST_HOLD;
        ST_HOLD:   state_nxt = ST_HOLD;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0; xpos <= '0; ypos <= '0; valid_pipe <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        x_pipe[i] <= '0;
        y_pipe[i] <= '0;
      end
      count <= '0; sum_x <= '0; sum_y <= '0; drain_cnt <= '0; qx <= '0;
      bx_min <= '0; bx_max <= '0; by_min <= '0; by_max <= '0;
      done <= 1'b0; edge_count <= '0; found <= 1'b0;
      x_min <= '0; x_max <= '0; y_min <= '0; y_max <= '0;
      x_centroid <= '0; y_centroid <= '0;
    end else begin
      valid_pipe[0] <= (state == ST_SCAN);
      x_pipe[0]     <= xpos;
      y_pipe[0]     <= ypos;
      for (int i = 1; i < READ_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        x_pipe[i]     <= x_pipe[i-1];
        y_pipe[i]     <= y_pipe[i-1];
      end

      if (hit) begin
        count <= count_nxt;
        sum_x <= sum_x_nxt;
        sum_y <= sum_y_nxt;
        if (px < bx_min) bx_min <= px;
        if (px > bx_max) bx_max <= px;
        if (py < by_min) by_min <= py;
        if (py > by_max) by_max <= py;
      end

      case (state)
        ST_IDLE: begin
          addr <= '0; xpos <= '0; ypos <= '0; valid_pipe <= '0;
          count <= '0; sum_x <= '0; sum_y <= '0; drain_cnt <= '0;
          bx_min <= '1; bx_max <= '0; by_min <= '1; by_max <= '0;
        end
        ST_SCAN: begin
          if (!scan_last) begin
            addr <= addr + ADDR_W'(1);
            if (xpos == X_LAST) begin
              xpos <= '0;
              ypos <= ypos + Y_W'(1);
            end else begin
              xpos <= xpos + X_W'(1);
            end
          end
        end
        ST_DRAIN: drain_cnt <= drain_cnt + 8'd1;
        ST_DIV_X: if (div_done) qx <= quotient;
        ST_FINISH: begin
          if (start) begin
            edge_count <= count;
            if (count != '0) begin
              x_min      <= bx_min;
              x_max      <= bx_max;
              y_min      <= by_min;
              y_max      <= by_max;
              x_centroid <= qx;
              y_centroid <= quotient[Y_W-1:0];
              found      <= (count >= ADDR_W'(MIN_COUNT));
            end else begin
              x_min <= '0; x_max <= '0; y_min <= '0; y_max <= '0;
              x_centroid <= '0; y_centroid <= '0; found <= 1'b0;
            end
          end
        end
        default: ;
      endcase

      if (!start)                  done <= 1'b0;
      else if (state == ST_FINISH) done <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_edge_centroid.sv
// Directed bench for edge_centroid on a reduced 32x24 image.
`default_nettype none

module tb_edge_centroid;

  localparam int W        = 32;
  localparam int H        = 24;
  localparam int N        = W * H;
  localparam int RL       = 2;
  localparam int SW       = 28;
  localparam int LAT_HIT  = N + RL + 2 * SW + 1;
  localparam int LAT_ZERO = N + RL + 1;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [3:0] mem [0:N-1];
  logic [3:0] rd1, rd2, rd1_b, rd2_b;

  logic        done, found, done_b, found_b;
  logic [18:0] addr, count, addr_b, count_b;
  logic [9:0]  xmin, xmax, xc, xmin_b, xmax_b, xc_b;
  logic [8:0]  ymin, ymax, yc, ymin_b, ymax_b, yc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd1   <= mem[addr[9:0]];
    rd2   <= rd1;
    rd1_b <= mem[addr_b[9:0]];
    rd2_b <= rd1_b;
  end

  edge_centroid #(.WIDTH(W), .HEIGHT(H), .READ_LAT(RL), .MIN_COUNT(1), .SUM_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .edge_data(rd2),
    .edge_memory_addr(addr), .edge_count(count), .x_min(xmin), .x_max(xmax),
    .y_min(ymin), .y_max(ymax), .x_centroid(xc), .y_centroid(yc), .found(found));

  edge_centroid #(.WIDTH(W), .HEIGHT(H), .READ_LAT(RL), .MIN_COUNT(4), .SUM_W(SW)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done_b), .edge_data(rd2_b),
    .edge_memory_addr(addr_b), .edge_count(count_b), .x_min(xmin_b), .x_max(xmax_b),
    .y_min(ymin_b), .y_max(ymax_b), .x_centroid(xc_b), .y_centroid(yc_b), .found(found_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 4'd0;
  endtask

  task automatic check_res(input string tag, input int c, input int x0, input int x1,
                           input int y0, input int y1, input int cx, input int cy, input int f);
    check({tag, "_count"}, 32'(count), c);
    check({tag, "_xmin"},  32'(xmin), x0);
    check({tag, "_xmax"},  32'(xmax), x1);
    check({tag, "_ymin"},  32'(ymin), y0);
    check({tag, "_ymax"},  32'(ymax), y1);
    check({tag, "_xc"},    32'(xc), cx);
    check({tag, "_yc"},    32'(yc), cy);
    check({tag, "_found"}, 32'(found), f);
  endtask

  // Next posedge is the cycle start is sampled in IDLE; counts edges to done.
  task automatic wait_done(input string tag, input int lat);
    int cyc = 0;
    @(posedge clk);
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 2000);
    check({tag, "_latency"}, cyc, lat);
  endtask

  task automatic run_pass(input string tag, input int lat);
    start = 1'b1;
    wait_done(tag, lat);
  endtask

  task automatic stop_pass(input string tag);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_clear"}, 32'(done), 0);
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(addr), 0);
    check_res("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Empty edge map: divides skipped, all results zero
    run_pass("zero", LAT_ZERO);
    check_res("zero", 0, 0, 0, 0, 0, 0, 0, 0);
    stop_pass("zero");

    // Single edge pixel at (10,5) -> address 170
    mem[170] = 4'h3;
    run_pass("single", LAT_HIT);
    check_res("single", 1, 10, 10, 5, 5, 10, 5, 1);
    stop_pass("single");
    check("single_held_count", 32'(count), 1);

    // Opposite corners: first and last address
    clear_mem();
    mem[0]   = 4'h1;
    mem[N-1] = 4'hF;
    run_pass("corner", LAT_HIT);
    check_res("corner", 2, 0, 31, 0, 23, 15, 11, 1);
    stop_pass("corner");

    // Filled rectangle x 10..19, y 4..13: sum_x 1450, sum_y 850 over 100
    clear_mem();
    for (int y = 4; y <= 13; y++)
      for (int x = 10; x <= 19; x++)
        mem[y * W + x] = ((x + y) % 2 != 0) ? 4'h1 : 4'h8;
    run_pass("rect", LAT_HIT);
    check_res("rect", 100, 10, 19, 4, 13, 14, 8, 1);
    stop_pass("rect");

    // Abort mid-scan, then a full pass on the single-pixel image
    clear_mem();
    mem[170] = 4'h3;
    start = 1'b1;
    repeat (100) @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("abort_done_seen", 32'(seen), 0);
    check("abort_held_count", 32'(count), 100);
    @(negedge clk);
    run_pass("restart", LAT_HIT);
    check_res("restart", 1, 10, 10, 5, 5, 10, 5, 1);
    stop_pass("restart");

    // Reset while the X divide is running, start held throughout
    start = 1'b1;
    @(posedge clk);
    repeat (N + RL + 10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("divrst_done", 32'(done), 0);
    check("divrst_addr", 32'(addr), 0);
    check_res("divrst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    wait_done("repeat", LAT_HIT);
    check_res("repeat", 1, 10, 10, 5, 5, 10, 5, 1);
    stop_pass("repeat");

    // Three edges: (2,3) (6,3) (7,20); MIN_COUNT=4 instance reports not found
    clear_mem();
    mem[3 * W + 2]  = 4'h1;
    mem[3 * W + 6]  = 4'h2;
    mem[20 * W + 7] = 4'h4;
    run_pass("three", LAT_HIT);
    check_res("three", 3, 2, 7, 3, 20, 5, 8, 1);
    check("min4_done",  32'(done_b), 1);
    check("min4_count", 32'(count_b), 3);
    check("min4_found", 32'(found_b), 0);
    check("min4_xc",    32'(xc_b), 5);
    check("min4_yc",    32'(yc_b), 8);
    stop_pass("three");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
